// File: rtl/tmr_vote_decoder_pkg.sv
// Shared types and defaults for the TMR vote decoder.
// Holds the report FSM states and the dissent mask bit positions.
package tmr_vote_decoder_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int CNT_W_DEF = 8;

  localparam int SRC_A = 0;
  localparam int SRC_B = 1;
  localparam int SRC_C = 2;

  typedef enum logic {
    IDLE,
    REPORT
  } state_e;

endpackage

// File: rtl/tmr_majority.sv
// Combinational bitwise 2-of-3 vote.
// Also produces the disagreeing bit positions and the dissent mask.
import tmr_vote_decoder_pkg::*;

module tmr_majority #(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] c_i,
  output logic [WIDTH-1:0] maj_o,
  output logic [WIDTH-1:0] dis_o,
  output logic [2:0]       src_o
);

  logic [WIDTH-1:0] da, db, dc;

  assign maj_o = (a_i & b_i) | (b_i & c_i) | (a_i & c_i);

  assign da = a_i ^ maj_o;
  assign db = b_i ^ maj_o;
  assign dc = c_i ^ maj_o;

  assign dis_o = da | db | dc;

  assign src_o[SRC_A] = |da;
  assign src_o[SRC_B] = |db;
  assign src_o[SRC_C] = |dc;

endmodule

// File: rtl/tmr_vote_decoder.sv
// Registered TMR voter with a single-entry error report channel,
// saturating mismatch counter and a sticky lost-report flag.
import tmr_vote_decoder_pkg::*;

module tmr_vote_decoder #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic [WIDTH-1:0] inC,
  input  logic             in_valid,
  input  logic             err_ack,
  input  logic             cnt_clr,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             err_req,
  output logic [2:0]       err_src,
  output logic [WIDTH-1:0] err_bits,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err_lost
);

  logic [WIDTH-1:0] maj, dis_bits;
  logic [2:0]       dis_src;
  logic             mismatch;

  tmr_majority #(
    .WIDTH (WIDTH)
  ) u_maj (
    .a_i   (inA),
    .b_i   (inB),
    .c_i   (inC),
    .maj_o (maj),
    .dis_o (dis_bits),
    .src_o (dis_src)
  );

  assign mismatch = in_valid && (|dis_bits);

  state_e           state_q, state_d;
  logic             cap, lost_set;
  logic [WIDTH-1:0] out_q, bits_q;
  logic             vld_q, lost_q;
  logic [2:0]       src_q;
  logic [CNT_W-1:0] cnt_q;

  always_comb begin
    state_d  = state_q;
    cap      = 1'b0;
    lost_set = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mismatch) begin
          state_d = REPORT;
          cap     = 1'b1;
        end
      end
      REPORT: begin
        if (err_ack) begin
          if (mismatch) cap = 1'b1;
          else state_d = IDLE;
        end else if (mismatch) begin
          lost_set = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      out_q   <= '0;
      vld_q   <= 1'b0;
      src_q   <= '0;
      bits_q  <= '0;
      cnt_q   <= '0;
      lost_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vld_q   <= in_valid;
      if (in_valid) out_q <= maj;
      if (cap) begin
        src_q  <= dis_src;
        bits_q <= dis_bits;
      end
      // clear wins over a same-cycle increment or lost flag
      if (cnt_clr) begin
        cnt_q  <= '0;
        lost_q <= 1'b0;
      end else begin
        if (mismatch && (cnt_q != '1))
          cnt_q <= cnt_q + CNT_W'(1);
        if (lost_set) lost_q <= 1'b1;
      end
    end
  end

  assign out       = out_q;
  assign out_valid = vld_q;
  assign err_req   = (state_q == REPORT);
  assign err_src   = src_q;
  assign err_bits  = bits_q;
  assign err_cnt   = cnt_q;
  assign err_lost  = lost_q;

endmodule

// File: tb/tb_tmr_vote_decoder.sv
// Scoreboard bench: reference model pushes expectations, monitor pops.
module tb_tmr_vote_decoder;

  logic       clk, rst;
  logic [7:0] inA, inB, inC;
  logic       in_valid, err_ack, cnt_clr;

  logic [7:0] out8, bits8, cnt8;
  logic       ov8, req8, lost8;
  logic [2:0] src8;
  logic [7:0] out2, bits2;
  logic [1:0] cnt2;
  logic       ov2, req2, lost2;
  logic [2:0] src2;

  tmr_vote_decoder #(.WIDTH(8), .CNT_W(8)) dut8 (
    .clk(clk), .rst(rst), .inA(inA), .inB(inB), .inC(inC),
    .in_valid(in_valid), .err_ack(err_ack), .cnt_clr(cnt_clr),
    .out(out8), .out_valid(ov8), .err_req(req8), .err_src(src8),
    .err_bits(bits8), .err_cnt(cnt8), .err_lost(lost8)
  );

  tmr_vote_decoder #(.WIDTH(8), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .inA(inA), .inB(inB), .inC(inC),
    .in_valid(in_valid), .err_ack(err_ack), .cnt_clr(cnt_clr),
    .out(out2), .out_valid(ov2), .err_req(req2), .err_src(src2),
    .err_bits(bits2), .err_cnt(cnt2), .err_lost(lost2)
  );

  typedef struct packed {
    logic [7:0] out;
    logic       req;
    logic [2:0] src;
    logic [7:0] bits;
    logic [7:0] c8;
    logic [1:0] c2;
    logic       lost;
  } st_t;

  logic [7:0] vq[$];
  st_t        sq[$];
  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  logic [7:0] m_out, m_bits;
  logic [2:0] m_src;
  logic       m_pend, m_lost;
  int         m_c8, m_c2;

  function automatic logic [7:0] vote(input logic [7:0] a, b, c);
    logic [7:0] r;
    for (int i = 0; i < 8; i++)
      r[i] = (int'(a[i]) + int'(b[i]) + int'(c[i])) >= 2;
    return r;
  endfunction

  always @(posedge clk) begin
    logic [7:0] mj, db;
    logic [2:0] sr;
    logic       mm;
    st_t        e;
    if (rst) begin
      m_out = 0; m_bits = 0; m_src = 0;
      m_pend = 0; m_lost = 0; m_c8 = 0; m_c2 = 0;
      vq.delete();
    end else begin
      mj = vote(inA, inB, inC);
      db = 0;
      for (int i = 0; i < 8; i++)
        if (!(inA[i] == inB[i] && inB[i] == inC[i])) db[i] = 1'b1;
      sr = {inC != mj, inB != mj, inA != mj};
      mm = in_valid && (db != 0);
      if (in_valid) begin
        m_out = mj;
        vq.push_back(mj);
      end
      if (mm) begin
        if (m_c8 < 255) m_c8++;
        if (m_c2 < 3) m_c2++;
        if (!m_pend || err_ack) begin
          m_pend = 1; m_src = sr; m_bits = db;
        end else begin
          m_lost = 1;
        end
      end else if (m_pend && err_ack) begin
        m_pend = 0;
      end
      if (cnt_clr) begin
        m_c8 = 0; m_c2 = 0; m_lost = 0;
      end
    end
    e.out = m_out; e.req = m_pend; e.src = m_src; e.bits = m_bits;
    e.c8 = m_c8[7:0]; e.c2 = m_c2[1:0]; e.lost = m_lost;
    sq.push_back(e);
  end

  always @(posedge clk) begin
    st_t e;
    logic [7:0] v;
    #1;
    if (ov8) begin
      if (vq.size() == 0) chk("vote_spurious", 1, 0);
      else begin
        v = vq.pop_front();
        chk("out", out8, v);
      end
    end
    if (sq.size() != 0) begin
      e = sq.pop_front();
      chk("out_hold", out8, e.out);
      chk("err_req", req8, e.req);
      chk("err_req2", req2, e.req);
      if (e.req) begin
        chk("err_src", src8, e.src);
        chk("err_bits", bits8, e.bits);
      end
      chk("err_cnt", cnt8, e.c8);
      chk("err_cnt2", cnt2, e.c2);
      chk("err_lost", lost8, e.lost);
      chk("err_lost2", lost2, e.lost);
    end
  end

  task automatic drv(input logic [7:0] a, b, c,
                     input logic v, ack, clr);
    @(negedge clk);
    inA = a; inB = b; inC = c;
    in_valid = v; err_ack = ack; cnt_clr = clr;
  endtask

  task automatic idle();
    drv(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [7:0] a, b, c;
    rst = 1'b1;
    inA = 0; inB = 0; inC = 0;
    in_valid = 0; err_ack = 0; cnt_clr = 0;
    #1;
    chk("rst_out", out8, 0);
    chk("rst_req", req8, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    drv(8'h5A, 8'h5A, 8'h5A, 1, 0, 0);
    drv(8'h5B, 8'h5A, 8'h5A, 1, 0, 0);
    idle();
    drv(8'h00, 8'h00, 8'h00, 0, 1, 0);
    drv(8'h01, 8'h02, 8'h03, 1, 0, 0);
    drv(8'h0F, 8'h0F, 8'h0E, 1, 0, 0);
    idle();
    drv(8'h80, 8'h00, 8'h00, 1, 1, 0);
    idle();
    drv(8'h00, 8'h00, 8'h00, 0, 1, 0);
    drv(8'h00, 8'h00, 8'h00, 0, 1, 1);
    for (int i = 0; i < 5; i++)
      drv(8'h10, 8'h11, 8'h11, 1, 1, 0);
    idle();
    drv(8'h00, 8'h00, 8'h00, 0, 1, 1);
    idle();

    drv(8'hC3, 8'hC3, 8'h43, 1, 0, 0);
    idle();
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_out", out8, 0);
    chk("mid_rst_ov", ov8, 0);
    chk("mid_rst_req", req8, 0);
    chk("mid_rst_src", src8, 0);
    chk("mid_rst_bits", bits8, 0);
    chk("mid_rst_cnt", cnt8, 0);
    chk("mid_rst_lost", lost8, 0);
    @(negedge clk);
    rst = 1'b0;
    drv(8'h77, 8'h77, 8'h77, 1, 0, 0);
    idle();

    for (int i = 0; i < 600; i++) begin
      a = 8'($urandom); b = a; c = a;
      case ($urandom_range(0, 4))
        1: a = a ^ 8'($urandom);
        2: b = b ^ 8'($urandom);
        3: begin
          b = b ^ 8'h0F & 8'($urandom);
          c = c ^ 8'hF0 & 8'($urandom);
        end
        4: begin
          b = 8'($urandom); c = 8'($urandom);
        end
        default: ;
      endcase
      drv(a, b, c, $urandom_range(0, 9) < 8,
          $urandom_range(0, 9) < 3, $urandom_range(0, 29) == 0);
    end
    idle();
    idle();
    repeat (2) @(negedge clk);
    chk("vote_drain", vq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/tmr_vote_decoder.md
TMR_VOTE_DECODER -- requirements
Module: tmr_vote_decoder

Interface
REQ-001 Parameter WIDTH, default 8: width of each data copy and of the voted output.
REQ-002 Parameter CNT_W, default 8: width of the mismatch counter.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 inA  input  WIDTH  data copy A.
REQ-006 inB  input  WIDTH  data copy B.
REQ-007 inC  input  WIDTH  data copy C.
REQ-008 in_valid  input  1  all three copies are valid this cycle.
REQ-009 err_ack  input  1  consumer accepts the current error report.
REQ-010 cnt_clr  input  1  synchronous clear of err_cnt and err_lost.
REQ-011 out  output  WIDTH  registered bitwise majority of inA/inB/inC.
REQ-012 out_valid  output  1  out holds a newly voted word.
REQ-013 err_req  output  1  an error report is pending.
REQ-014 err_src  output  3  one-hot-or-more mask of dissenting copies {C,B,A} for the report.
REQ-015 err_bits  output  WIDTH  bit positions that disagreed in the reported word.
REQ-016 err_cnt  output  CNT_W  saturating count of mismatching valid words.
REQ-017 err_lost  output  1  sticky: a mismatch arrived while a report was already pending.

Function
REQ-018 Vote: per bit, maj = (A&B)|(B&C)|(A&C); out <= maj and out_valid <= 1 one cycle after in_valid=1; otherwise out_valid <= 0 and out holds its value.
REQ-019 Mismatch: dis_bits = (A^maj)|(B^maj)|(C^maj); a word mismatches when in_valid=1 and dis_bits != 0.
REQ-020 Dissent mask: bit0 = |(A^maj), bit1 = |(B^maj), bit2 = |(C^maj); a word may set more than one bit when different copies lose on different bit positions.
REQ-021 Report FSM states: IDLE, REPORT.
REQ-022 IDLE: on mismatch capture err_src/err_bits, go to REPORT; err_req = 1 from the next cycle.
REQ-023 REPORT: err_req = 1, err_src/err_bits held stable until accepted.
REQ-024 REPORT with err_ack=1 and no mismatch -> IDLE; err_req = 0 next cycle; err_src/err_bits keep their last value.
REQ-025 REPORT with err_ack=1 and a mismatch in the same cycle -> stay in REPORT, capture the new word, no lost report.
REQ-026 REPORT with err_ack=0 and a mismatch -> keep the old report, set err_lost.
REQ-027 err_ack in IDLE is ignored.
REQ-028 err_cnt increments by 1 on every mismatch, independent of FSM state, and saturates at 2^CNT_W-1.
REQ-029 cnt_clr=1 forces err_cnt=0 and err_lost=0 next cycle, taking priority over a same-cycle increment or set.
REQ-030 Vote latency is exactly 1 cycle; report latency is exactly 1 cycle after the mismatching word.

Reset
REQ-031 While rst=1: out=0, out_valid=0, err_req=0, err_src=0, err_bits=0, err_cnt=0, err_lost=0, FSM=IDLE.
REQ-032 Asserting rst mid-report drops the report without handshake; inputs are ignored until the first clk edge after rst deasserts.

Structure
REQ-033 A shared package holds the FSM state enum (IDLE, REPORT), the err_src bit indices (SRC_A=0, SRC_B=1, SRC_C=2) and the default WIDTH and CNT_W values.
REQ-034 One sub-module, tmr_majority (combinational, WIDTH-wide vote plus dis_bits and dissent mask), is instantiated once; the FSM, counter and registers are in the top.

Verification
REQ-035 Clean data: A=B=C=8'h5A with in_valid=1 -> out=8'h5A, out_valid=1 next cycle, err_req=0, err_cnt=0.
REQ-036 Single flip: A=8'h5B, B=C=8'h5A -> out=8'h5A; next cycle err_req=1, err_src=3'b001, err_bits=8'h01, err_cnt=1.
REQ-037 Split dissent: A=8'h01, B=8'h02, C=8'h03 -> out=8'h03, err_src=3'b011, err_bits=8'h03.
REQ-038 Pending report: mismatch, no ack, second mismatch -> report unchanged, err_lost=1, err_cnt=2; then err_ack together with a third mismatch -> err_req stays 1 and the third word's data is captured.
REQ-039 Saturation: CNT_W=2, five mismatches -> err_cnt=3; cnt_clr -> err_cnt=0, err_lost=0.
REQ-040 Reset mid-report: rst pulse while err_req=1 -> all outputs 0 immediately; next clean word produces out_valid only.
